// File: rtl/peek_controller_pkg.sv
// Shared definitions for the UART peek controller: FSM state encoding, frame sizes, error payloads.
package peek_controller_pkg;

    typedef enum logic [1:0] {
        PeekCollect = 2'd0,
        PeekIssue   = 2'd1,
        PeekWait    = 2'd2,
        PeekSend    = 2'd3
    } peek_state_e;

    localparam int unsigned PEEK_FRAME_BYTES = 5;
    localparam int unsigned PEEK_RSP_BYTES   = 4;

    localparam logic [31:0] PEEK_ERR_ID      = 32'hFFFF_FFFF;
    localparam logic [31:0] PEEK_ERR_TIMEOUT = 32'hDEAD_BEEF;

    // Byte idx of a response word, LSB first.
    function automatic logic [7:0] peek_rsp_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/peek_frame_assembler.sv
// Collects a 5-byte request frame: 4 address bytes (LSB first) followed by a core ID byte.
module peek_frame_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        frame_done_o,
    output logic [31:0] frame_addr_o,
    output logic [7:0]  frame_core_o
);
    import peek_controller_pkg::*;

    localparam logic [2:0] LastIdx = 3'(PEEK_FRAME_BYTES - 1);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;

    // Strobe and frame fields are combinational so the consumer can act on the 5th byte's edge.
    assign frame_done_o = byte_valid_i && (cnt_q == LastIdx);
    assign frame_addr_o = shift_q;
    assign frame_core_o = byte_i;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (byte_valid_i) begin
            shift_d = {byte_i, shift_q[31:8]};
            cnt_d   = (cnt_q == LastIdx) ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/peek_controller.sv
// UART-driven memory peek controller: frame in, one read request out, 4-byte response back.
// Optional build macro PEEK_TIMEOUT_EN adds a response timeout in the wait state.
module peek_controller #(
    parameter int unsigned CORE_COUNT     = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [7:0]        req_core,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [7:0]        drop_cnt
);
    import peek_controller_pkg::*;

    localparam logic [1:0] StCollect = PeekCollect;
    localparam logic [1:0] StIssue   = PeekIssue;
    localparam logic [1:0] StWait    = PeekWait;
    localparam logic [1:0] StSend    = PeekSend;
    localparam logic [1:0] LastTx    = 2'(PEEK_RSP_BYTES - 1);

    logic [1:0]        state_q, state_d;
    logic [31:0]       payload_q, payload_d;
    logic [1:0]        tx_idx_q, tx_idx_d;
    logic [7:0]        req_core_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [7:0]        drop_q;

    logic              frame_done;
    logic [31:0]       frame_addr;
    logic [7:0]        frame_core;
    logic              id_ok;
    logic [31:0]       rsp_word;
    logic              tmo_hit;

    assign busy = (state_q != StCollect);

    peek_frame_assembler u_frame (
        .clk_i        (clk),
        .rst_i        (rst),
        .byte_valid_i (rx_valid && !busy),
        .byte_i       (rx_data),
        .frame_done_o (frame_done),
        .frame_addr_o (frame_addr),
        .frame_core_o (frame_core)
    );

    assign id_ok    = ({24'd0, frame_core} < CORE_COUNT);
    // Zero-extends or truncates to the fixed 32-bit response payload.
    assign rsp_word = 32'(rsp_data);

`ifdef PEEK_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q;

    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q != StWait) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign tmo_hit            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        tx_idx_d  = tx_idx_q;
        case (state_q)
            StCollect: begin
                if (frame_done) begin
                    if (id_ok) begin
                        state_d = StIssue;
                    end else begin
                        state_d   = StSend;
                        payload_d = PEEK_ERR_ID;
                        tx_idx_d  = 2'd0;
                    end
                end
            end
            StIssue: begin
                if (req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A response arriving on the timeout cycle still wins.
                if (rsp_valid) begin
                    state_d   = StSend;
                    payload_d = rsp_word;
                    tx_idx_d  = 2'd0;
                end else if (tmo_hit) begin
                    state_d   = StSend;
                    payload_d = PEEK_ERR_TIMEOUT;
                    tx_idx_d  = 2'd0;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    if (tx_idx_q == LastTx) begin
                        state_d  = StCollect;
                        tx_idx_d = 2'd0;
                    end else begin
                        tx_idx_d = tx_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StCollect;
            payload_q  <= '0;
            tx_idx_q   <= '0;
            req_core_q <= '0;
            req_addr_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            tx_idx_q  <= tx_idx_d;
            if (frame_done) begin
                req_core_q <= frame_core;
                req_addr_q <= ADDR_W'(frame_addr);
            end
            if (rx_valid && busy && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign req_valid = (state_q == StIssue);
    assign req_core  = req_core_q;
    assign req_addr  = req_addr_q;
    assign tx_valid  = (state_q == StSend);
    assign tx_data   = peek_rsp_byte(payload_q, tx_idx_q);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_peek_controller.sv
// Directed self-checking bench for peek_controller; timeout case runs when PEEK_TIMEOUT_EN is defined.
module tb_peek_controller;

    localparam int unsigned CORE_COUNT     = 4;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [7:0]        tx_data;
    logic              req_valid;
    logic              req_ready = 1'b0;
    logic [7:0]        req_core;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid = 1'b0;
    logic [DATA_W-1:0] rsp_data = '0;
    logic              busy;
    logic [7:0]        drop_cnt;

    int checks    = 0;
    int errors    = 0;
    int req_count = 0;

    peek_controller #(
        .CORE_COUNT     (CORE_COUNT),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_core  (req_core),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) req_count <= req_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] addr, input logic [7:0] id);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        send_byte(id);
    endtask

    task automatic handshake_req();
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        rsp_valid = 1'b1;
        rsp_data  = data;
        @(negedge clk);
        rsp_valid = 1'b0;
    endtask

    task automatic recv_tx(input string tag, input logic [31:0] word, input int bound);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!tx_valid && n < bound) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_valid"}, 32'(tx_valid), 32'd1);
            check({tag, "_byte"}, 32'(tx_data), 32'(word[8*i +: 8]));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
        check("rst_req_core", 32'(req_core), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);

        // Basic peek: 3C 02 00 00 03
        send_frame(32'h0000_023C, 8'h03);
        check("t1_req_latency", 32'(req_valid), 32'd1);
        check("t1_req_core", 32'(req_core), 32'd3);
        check("t1_req_addr", req_addr, 32'h0000_023C);
        check("t1_busy", 32'(busy), 32'd1);
        handshake_req();
        check("t1_wait_req_valid", 32'(req_valid), 32'd0);
        check("t1_wait_tx_valid", 32'(tx_valid), 32'd0);
        check("t1_req_count", 32'(req_count), 32'd1);
        respond(32'h1122_3344);
        check("t1_tx_latency", 32'(tx_valid), 32'd1);
        recv_tx("t1_tx", 32'h1122_3344, 4);

        // Stray response while idle
        respond(32'h0000_0055);
        check("stale_rsp_busy", 32'(busy), 32'd0);
        check("stale_rsp_tx", 32'(tx_valid), 32'd0);

        // Out-of-range core ID
        send_frame(32'h0000_023C, 8'h07);
        check("t2_no_req", 32'(req_valid), 32'd0);
        check("t2_tx_latency", 32'(tx_valid), 32'd1);
        recv_tx("t2_tx", 32'hFFFF_FFFF, 4);
        check("t2_req_count", 32'(req_count), 32'd1);

        // Backpressured request
        send_frame(32'hA5B6_C7D8, 8'h01);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(req_valid), 32'd1);
            check("t3_hold_addr", req_addr, 32'hA5B6_C7D8);
            check("t3_hold_core", 32'(req_core), 32'd1);
            @(negedge clk);
        end
        check("t3_no_early_req", 32'(req_count), 32'd1);
        handshake_req();
        check("t3_one_req", 32'(req_count), 32'd2);
        check("t3_req_drop", 32'(req_valid), 32'd0);
        respond(32'hCAFE_F00D);
        recv_tx("t3_tx", 32'hCAFE_F00D, 4);

        // Drops during WAIT and SEND
        send_frame(32'h0000_0010, 8'h02);
        handshake_req();
        send_byte(8'h3C);
        send_byte(8'h02);
        send_byte(8'h00);
        check("t4_drop_wait", 32'(drop_cnt), 32'd3);
        check("t4_still_wait", 32'(busy), 32'd1);
        respond(32'h0BAD_F00D);
        send_byte(8'h11);
        send_byte(8'h22);
        check("t4_drop_send", 32'(drop_cnt), 32'd5);
        check("t4_send_byte0", 32'(tx_data), 32'h0000_000D);
        recv_tx("t4_tx", 32'h0BAD_F00D, 4);
        send_frame(32'h0000_1234, 8'h00);
        check("t4_next_addr", req_addr, 32'h0000_1234);
        check("t4_next_core", 32'(req_core), 32'd0);
        check("t4_next_req", 32'(req_valid), 32'd1);
        handshake_req();
        respond(32'h89AB_CDEF);
        recv_tx("t4_next_tx", 32'h89AB_CDEF, 4);
        check("t4_drop_kept", 32'(drop_cnt), 32'd5);

        // drop_cnt saturation
        send_frame(32'h0000_0020, 8'h03);
        handshake_req();
        repeat (260) send_byte(8'hAA);
        check("sat_drop", 32'(drop_cnt), 32'd255);
        respond(32'h0000_0001);
        recv_tx("sat_tx", 32'h0000_0001, 4);

        // Reset mid-SEND after two bytes
        send_frame(32'h0000_0030, 8'h09);
        check("t5_send", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        tx_ready = 1'b0;
        check("t5_third_byte", 32'(tx_data), 32'h0000_00FF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_tx_valid", 32'(tx_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        check("t5_tx_data", 32'(tx_data), 32'd0);
        check("t5_req_addr", req_addr, 32'd0);
        tx_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_valid) seen++;
        end
        tx_ready = 1'b0;
        check("t5_no_partial", 32'(seen), 32'd0);
        send_frame(32'h0000_BEEF, 8'h02);
        check("t5_fresh_addr", req_addr, 32'h0000_BEEF);
        check("t5_fresh_core", 32'(req_core), 32'd2);
        handshake_req();
        respond(32'h7654_3210);
        recv_tx("t5_fresh_tx", 32'h7654_3210, 4);

`ifdef PEEK_TIMEOUT_EN
        // No response: timeout payload, then a late response is ignored
        send_frame(32'h0000_0040, 8'h01);
        handshake_req();
        recv_tx("tmo_tx", 32'hDEAD_BEEF, 64);
        respond(32'h1234_5678);
        check("tmo_late_busy", 32'(busy), 32'd0);
        check("tmo_late_tx", 32'(tx_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
